// File: rtl/painel_controle_rolagem.sv
// painel_controle_rolagem: scroll controller driving a universal shift register row
module painel_controle_rolagem #(
    parameter int WIDTH = 8,
    parameter int SPW = 8,
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [WIDTH-1:0] pattern,
    input  logic             dir,
    input  logic             rotate,
    input  logic             fill_bit,
    input  logic [SPW-1:0]   speed,
    input  logic [WIDTH-1:0] row_q,
    output logic [1:0]       sel,
    output logic [WIDTH-1:0] par_data,
    output logic             ser_msb,
    output logic             ser_lsb,
    output logic             busy,
    output logic             lap_done,
    output logic [CW-1:0]    step_cnt
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    state_t state, state_n;
    logic [SPW-1:0] div, div_n, speed_l;
    logic dir_l, rot_l, fill_l;
    logic load_entry, shift_n, busy_n, lap_n;
    logic [1:0] sel_n;
    logic [CW-1:0] cnt_n;
    assign ser_msb = rot_l ? row_q[0] : fill_l;
    assign ser_lsb = rot_l ? row_q[WIDTH-1] : fill_l;
    // state register plus every registered output and latched configuration
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= 2'b11;
            par_data <= '0;
            busy     <= 1'b0;
            lap_done <= 1'b0;
            step_cnt <= '0;
            div      <= '0;
            speed_l  <= '0;
            dir_l    <= 1'b0;
            rot_l    <= 1'b0;
            fill_l   <= 1'b0;
        end else begin
            state    <= state_n;
            sel      <= sel_n;
            busy     <= busy_n;
            lap_done <= lap_n;
            step_cnt <= cnt_n;
            div      <= div_n;
            if (load_entry) begin
                par_data <= pattern;
                speed_l  <= speed;
                dir_l    <= dir;
                rot_l    <= rotate;
                fill_l   <= fill_bit;
            end
        end
    end
    // next state: start restarts from anywhere but LOAD, stop or a finished fill lap ends RUN
    always_comb begin
        state_n = (start && state != LOAD) ? LOAD :
                  (state == LOAD) ? RUN :
                  (state == RUN && (stop || (lap_done && !rot_l))) ? IDLE : state;
    end
    // next outputs: the LOAD cycle counts as divider slot 0, so a step lands speed+1 cycles after it
    always_comb begin
        load_entry = state_n == LOAD && state != LOAD;
        shift_n    = state_n == RUN && div == speed_l;
        sel_n      = (state_n == LOAD) ? 2'b00 : shift_n ? (dir_l ? 2'b10 : 2'b01) : 2'b11;
        busy_n     = state_n != IDLE;
        lap_n      = shift_n && step_cnt == CW'(WIDTH - 1);
        cnt_n      = load_entry ? '0 :
                     !shift_n ? step_cnt :
                     (step_cnt == CW'(WIDTH - 1)) ? '0 : step_cnt + 1'b1;
        div_n      = (state_n != RUN) ? '0 : (div == speed_l) ? '0 : div + 1'b1;
    end
endmodule

// File: tb/tb_painel_controle_rolagem.sv
// tb_painel_controle_rolagem: scoreboard bench with an 8-bit universal shift register plant
module tb_painel_controle_rolagem;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, dir = 1'b0, rotate = 1'b0, fill_bit = 1'b0;
    logic [7:0] pattern = '0, speed = '0;
    logic [7:0] row_q = '0;
    logic [1:0] sel;
    logic [7:0] par_data;
    logic ser_msb, ser_lsb, busy, lap_done;
    logic [2:0] step_cnt;
    int tests = 0, fails = 0;

    typedef struct packed {logic [1:0] sel; logic [7:0] row; logic [2:0] cnt; logic lap;} exp_t;
    typedef struct {string name; logic [31:0] act; logic [31:0] exp;} chk_t;
    exp_t q[$];
    chk_t cq[$];
    exp_t pend;
    bit pend_v = 0;

    painel_controle_rolagem #(.WIDTH(8), .SPW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pattern(pattern),
        .dir(dir), .rotate(rotate), .fill_bit(fill_bit), .speed(speed), .row_q(row_q),
        .sel(sel), .par_data(par_data), .ser_msb(ser_msb), .ser_lsb(ser_lsb),
        .busy(busy), .lap_done(lap_done), .step_cnt(step_cnt)
    );

    always #5 clk = ~clk;

    // row plant: per-bit 4:1 muxes of a universal shift register
    always_ff @(posedge clk)
        row_q <= (sel == 2'b00) ? par_data :
                 (sel == 2'b01) ? {ser_msb, row_q[7:1]} :
                 (sel == 2'b10) ? {row_q[6:0], ser_lsb} : row_q;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: drains direct checks, checks the row after each action, pops one record per action
    always @(negedge clk) begin
        while (cq.size() != 0) begin
            chk_t c;
            c = cq.pop_front();
            cmp(c.name, c.act, c.exp);
        end
        if (pend_v) begin
            cmp("row_after", {24'd0, row_q}, {24'd0, pend.row});
            pend_v = 0;
        end
        if (sel != 2'b11) begin
            if (q.size() == 0) cmp("unexpected_action", {30'd0, sel}, 32'd3);
            else begin
                pend = q.pop_front();
                pend_v = 1;
                cmp("sel", {30'd0, sel}, {30'd0, pend.sel});
                cmp("step_cnt", {29'd0, step_cnt}, {29'd0, pend.cnt});
                cmp("lap_done", {31'd0, lap_done}, {31'd0, pend.lap});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        cq.push_back('{n, a, e});
    endtask

    task automatic act(input logic [1:0] s, input logic [7:0] r, input logic [2:0] c, input logic l);
        exp_t e;
        e.sel = s;
        e.row = r;
        e.cnt = c;
        e.lap = l;
        q.push_back(e);
    endtask

    task automatic cfg(input logic [7:0] p, input logic d, input logic r, input logic f, input logic [7:0] s);
        pattern = p;
        dir = d;
        rotate = r;
        fill_bit = f;
        speed = s;
    endtask

    initial begin
        logic [7:0] rr [8];
        logic [7:0] fl [8];
        int n;
        rr = '{8'hC0, 8'h60, 8'h30, 8'h18, 8'h0C, 8'h06, 8'h03, 8'h81};
        fl = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
        // reset held with start high: nothing may be issued
        start = 1'b1;
        cfg(8'hA5, 1'b0, 1'b1, 1'b0, 8'd3);
        tick();
        tick();
        chk("rst_sel", {30'd0, sel}, 32'd3);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_par", {24'd0, par_data}, 32'd0);
        chk("rst_cnt", {29'd0, step_cnt}, 32'd0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        // load A5 with speed 3, one right rotate step, then stop
        act(2'b00, 8'hA5, 3'd0, 1'b0);
        act(2'b01, 8'hD2, 3'd1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("load_sel", {30'd0, sel}, 32'd0);
        chk("load_par", {24'd0, par_data}, 32'hA5);
        chk("load_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_sel", {30'd0, sel}, 32'd3);
        end
        chk("loaded_row", {24'd0, row_q}, 32'hA5);
        tick();
        chk("first_step_sel", {30'd0, sel}, 32'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_sel", {30'd0, sel}, 32'd3);
        chk("stop_busy", {31'd0, busy}, 32'd0);
        // rotate right 81 at full speed for one lap
        cfg(8'h81, 1'b0, 1'b1, 1'b0, 8'd0);
        act(2'b00, 8'h81, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) act(2'b01, rr[i], 3'(i + 1), i == 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk("rot_lap", {31'd0, lap_done}, {31'd0, i == 8});
            chk("rot_cnt", {29'd0, step_cnt}, i % 8);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("rot_row", {24'd0, row_q}, 32'h81);
        chk("rot_stop_sel", {30'd0, sel}, 32'd3);
        // fill left with zeros at speed 1, ends on its own
        cfg(8'hFF, 1'b1, 1'b0, 1'b0, 8'd1);
        act(2'b00, 8'hFF, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) act(2'b10, fl[i], 3'(i + 1), i == 7);
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        chk("fill_timeout", {31'd0, n < 40}, 32'd1);
        chk("fill_row", {24'd0, row_q}, 32'h00);
        chk("fill_sel", {30'd0, sel}, 32'd3);
        // rotate left, stop after three steps, row must freeze
        cfg(8'h01, 1'b1, 1'b1, 1'b0, 8'd0);
        act(2'b00, 8'h01, 3'd0, 1'b0);
        act(2'b10, 8'h02, 3'd1, 1'b0);
        act(2'b10, 8'h04, 3'd2, 1'b0);
        act(2'b10, 8'h08, 3'd3, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop3_sel", {30'd0, sel}, 32'd3);
        chk("stop3_cnt", {29'd0, step_cnt}, 32'd3);
        repeat (2) tick();
        chk("frozen_row", {24'd0, row_q}, 32'h08);
        // start and stop together while running: restart wins
        cfg(8'h3C, 1'b0, 1'b1, 1'b0, 8'd0);
        act(2'b00, 8'h3C, 3'd0, 1'b0);
        act(2'b01, 8'h1E, 3'd1, 1'b0);
        act(2'b01, 8'h0F, 3'd2, 1'b0);
        act(2'b00, 8'hF0, 3'd0, 1'b0);
        act(2'b10, 8'hE1, 3'd1, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        cfg(8'hF0, 1'b1, 1'b1, 1'b0, 8'd2);
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        chk("restart_sel", {30'd0, sel}, 32'd0);
        chk("restart_cnt", {29'd0, step_cnt}, 32'd0);
        chk("restart_par", {24'd0, par_data}, 32'hF0);
        repeat (2) tick();
        chk("restart_wait_sel", {30'd0, sel}, 32'd3);
        tick();
        chk("restart_step_sel", {30'd0, sel}, 32'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("restart_row", {24'd0, row_q}, 32'hE1);
        // reset during a step cycle
        cfg(8'h81, 1'b0, 1'b1, 1'b0, 8'd0);
        act(2'b00, 8'h81, 3'd0, 1'b0);
        act(2'b01, 8'hC0, 3'd1, 1'b0);
        act(2'b01, 8'h60, 3'd2, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (2) tick();
        rst_n = 1'b0;
        tick();
        chk("midrst_sel", {30'd0, sel}, 32'd3);
        chk("midrst_cnt", {29'd0, step_cnt}, 32'd0);
        chk("midrst_lap", {31'd0, lap_done}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        n = 0;
        while ((q.size() != 0 || pend_v) && n < 20) begin
            tick();
            n++;
        end
        chk("drain", q.size() + 32'(pend_v), 32'd0);
        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
